scpu_issue_unit: RTL
====================

Name: scpu_issue_unit

Overview:
- Sits directly upstream of the SCPU core and drives its in_valid and instruction inputs.
- Accepts 19-bit instructions from a host through a valid/ready handshake and buffers them in a FIFO.
- Issues one instruction per cycle in program order. The core has no forwarding, so the block inserts NOP bubbles whenever an instruction would read a register still in flight.
- Also provides stall statistics and an idle indication to the testbench or top level.

Parameters:
- FIFO_DEPTH, 8, instruction buffer entries; power of two, minimum 2.
- HAZARD_DIST, 3, number of previously issued slots checked for RAW conflicts. This matches the core's 4-cycle register read-to-write distance.
- NOP_INSTR, 19'h70000, opcode 3'b111 encoding; the core performs no register or memory write for it.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- host_valid  in  1  host offers host_instr this cycle.
- host_instr  in  19  instruction: [18:16] op, [15:12] rs, [11:8] rt, [7:4] rd, [3:0] rl/func.
- host_ready  out  1  FIFO can accept; combinational, equals !full.
- cpu_busy  in  1  core busy input; when 1, no new instruction is issued.
- in_valid  out  1  registered; current instruction slot is real.
- instruction  out  19  registered; instruction presented to the core.
- idle  out  1  registered; FIFO empty and every scoreboard slot clear.
- stall_cnt  out  16  registered, saturating count of hazard bubbles.

Behaviour:
- Reset (asynchronous, active-low; clock clk): in_valid=0, instruction=NOP_INSTR, stall_cnt=0, idle=1. FIFO read/write pointers and count are 0. All scoreboard slots are empty (no destination).
- Host push: occurs on a rising edge where host_valid && host_ready. host_instr is written at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- Full FIFO: host_ready=0 and host_instr is ignored.
- Simultaneous push and pop on a full FIFO is not allowed, because host_ready is already 0.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
- Sources read per opcode:
  - 000 (ALU) and 001 (MULT): rs, rt.
  - 010 (SQUARE), 011 (ADDI), 100 (SUBI), 110 (LOAD): rs.
  - 101 (STORE): rs, rt.
  - 111 (NOP): none.
- Destinations written per opcode:
  - 000: rd.
  - 001, 010: rd and rl.
  - 011, 100, 110: rt.
  - 101, 111: none.
- Scoreboard: a shift register of HAZARD_DIST entries. Each entry holds a 16-bit one-hot-OR destination mask.
  - Entry 0 is the instruction currently on the output register.
  - Every edge shifts in the mask of the newly loaded output. A NOP or bubble shifts in mask 0.
- Hazard: the FIFO head is non-empty and any of its source registers is set in the OR of all scoreboard masks.
- Issue decision, taken each edge with FIFO non-empty:
  - If cpu_busy=0 and no hazard: pop the head into instruction and set in_valid=1.
  - Otherwise: load NOP_INSTR and set in_valid=0.
  - If the cause was a hazard and cpu_busy=0: stall_cnt increments, saturating at 16'hFFFF.
  - cpu_busy alone does not count as a stall.
- FIFO empty: load NOP_INSTR, in_valid=0, no stall count.
- Latency: an instruction pushed at edge N into an empty FIFO with a clear scoreboard appears on the outputs after edge N+1. There is no bypass from host to output.
- Back-to-back dependent instructions: the consumer issues exactly HAZARD_DIST+1 cycles after the producer, with HAZARD_DIST bubbles between them.
- Independent instructions issue every cycle with no bubbles.
- Dependency on rl: a MULT writing rd=2, rl=3 followed by a reader of r3 stalls exactly like a reader of r2.
- r0 is an ordinary register; hazards on r0 are tracked like any other register.
- Store-then-load to the same address needs no memory ordering interlock; program order is preserved.
- idle = (count==0) && (OR of scoreboard masks == 0), registered.
- Reset mid-operation: FIFO contents are discarded, the output is forced to NOP immediately (asynchronously), and the scoreboard is cleared.

Test Plan:
- Reset, then stay idle for 5 cycles -> in_valid=0, instruction=19'h70000, idle=1, host_ready=1, stall_cnt=0.
- Push ADDI r1=r0+5 then ADD r2=r1+r1 on consecutive cycles -> ADDI issues at cycle t and ADD issues at t+4. There are 3 NOP slots between them with in_valid=0, and stall_cnt=3.
- Push 8 independent ADDIs, each with a distinct rt and rs=r0 -> all issue on consecutive cycles and stall_cnt stays 0.
- Hold host_valid=1 with issue blocked by cpu_busy=1 -> after 8 accepts host_ready=0, and the 9th instruction is not accepted. Release cpu_busy -> all 8 issue in order, and host_ready returns to 1 after the first pop.
- MULT rs=r1, rt=r2, rd=r4, rl=r5, followed by STORE rs=r0, rt=r5 -> the STORE is delayed 3 bubbles. A following independent SUBI on r6 issues directly after the STORE.
- Assert rst_n=0 while 4 instructions are buffered and one hazard is pending -> outputs return to reset values immediately. After release, no stale instruction issues and idle=1.

Source files
------------

// File: rtl/scpu_issue_unit_if.sv
// Host-side instruction handshake into the SCPU issue unit.
// The host offers host_instr with host_valid; host_ready tells it the buffer has room.
interface scpu_issue_unit_if;
  logic        host_valid;
  logic [18:0] host_instr;
  logic        host_ready;

  modport master (output host_valid, output host_instr, input host_ready);
  modport slave  (input host_valid, input host_instr, output host_ready);
endinterface

// File: rtl/scpu_issue_unit.sv
// In-order issue stage in front of the SCPU core: buffers host instructions and
// inserts NOP bubbles while any source register is still in flight.
module scpu_issue_unit #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          HAZARD_DIST = 3,
  parameter logic [18:0] NOP_INSTR   = 19'h70000
) (
  input  logic                clk,
  input  logic                rst_n,
  scpu_issue_unit_if.slave    host,
  input  logic                cpu_busy,
  output logic                in_valid,
  output logic [18:0]         instruction,
  output logic                idle,
  output logic [15:0]         stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_ALU    = 3'b000,
    OP_MULT   = 3'b001,
    OP_SQUARE = 3'b010,
    OP_ADDI   = 3'b011,
    OP_SUBI   = 3'b100,
    OP_STORE  = 3'b101,
    OP_LOAD   = 3'b110,
    OP_NOP    = 3'b111
  } op_e;

  function automatic logic [15:0] reg_bit(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  function automatic logic [15:0] src_mask(input logic [18:0] ins);
    case (op_e'(ins[18:16]))
      OP_ALU, OP_MULT, OP_STORE:           return reg_bit(ins[15:12]) | reg_bit(ins[11:8]);
      OP_SQUARE, OP_ADDI, OP_SUBI, OP_LOAD: return reg_bit(ins[15:12]);
      default:                             return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] dst_mask(input logic [18:0] ins);
    case (op_e'(ins[18:16]))
      OP_ALU:                     return reg_bit(ins[7:4]);
      OP_MULT, OP_SQUARE:         return reg_bit(ins[7:4]) | reg_bit(ins[3:0]);
      OP_ADDI, OP_SUBI, OP_LOAD:  return reg_bit(ins[11:8]);
      default:                    return 16'h0000;
    endcase
  endfunction

  logic [18:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [15:0]      sb [HAZARD_DIST];
  logic [15:0]      sb_or, sb_or_next, issue_mask;
  logic [18:0]      head;
  logic             empty, full, push, pop, hazard;

  assign empty          = (count == '0);
  assign full           = (count == CNT_W'(FIFO_DEPTH));
  assign host.host_ready = !full;
  assign push           = host.host_valid && !full;
  assign head           = mem[rd_ptr];

  // Everything driven here gets a default first so no path leaves a latch behind.
  // NOTE: assign a default to every always_comb output before any branch, or synthesis infers a latch.
  always_comb begin
    sb_or = '0;
    for (int i = 0; i < HAZARD_DIST; i++) sb_or |= sb[i];
    hazard     = !empty && ((src_mask(head) & sb_or) != 16'h0000);
    pop        = !empty && !cpu_busy && !hazard;
    issue_mask = pop ? dst_mask(head) : 16'h0000;
    sb_or_next = issue_mask;
    for (int i = 0; i < HAZARD_DIST - 1; i++) sb_or_next |= sb[i];
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: instruction storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host.host_instr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Scoreboard entry 0 tracks whatever sits on the output register this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HAZARD_DIST; i++) sb[i] <= 16'h0000;
    end else begin
      sb[0] <= issue_mask;
      for (int i = 1; i < HAZARD_DIST; i++) sb[i] <= sb[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid    <= 1'b0;
      instruction <= NOP_INSTR;
      stall_cnt   <= 16'h0000;
      idle        <= 1'b1;
    end else begin
      in_valid    <= pop;
      instruction <= pop ? head : NOP_INSTR;
      // Only hazard bubbles count; a busy core holding issue is not a stall.
      if (hazard && !cpu_busy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'h0001;
      idle <= (count_next == '0) && (sb_or_next == 16'h0000);
    end
  end

endmodule
